// File: rtl/kmap_sweep_checker.sv
// Truth-table sweeper for an N_IN-input combinational block: walks every input vector
// in binary or Gray order, compares the block's output to a latched minterm mask, counts mismatches.
module kmap_sweep_checker #(
    parameter int unsigned N_IN = 4,
    parameter int unsigned HOLD = 2,
    parameter int unsigned GRAY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   mask,
    input  logic                 dut_y,
    output logic [N_IN-1:0]      vec,
    output logic                 running,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic                 fail_valid,
    output logic [N_IN-1:0]      first_fail
);

    localparam int unsigned NV = 2 ** N_IN;
    localparam int unsigned EW = N_IN + 1;
    localparam int unsigned HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD_ST = 2'd1,
        DONE_ST = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NV-1:0]       mask_q, mask_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [EW-1:0]       err_q, err_d;
    logic                fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]     first_fail_q, first_fail_d;

    logic                mism_c;
    logic [EW-1:0]       err_inc_c;
    logic                begin_c;

    function automatic logic [N_IN-1:0] map_idx(input logic [N_IN-1:0] i);
        if (GRAY != 0) begin
            return i ^ (i >> 1);
        end
        return i;
    endfunction

    // Compare always uses the vector actually driven, so Gray order needs no remap here
    assign mism_c    = (dut_y != mask_q[vec_q]);
    assign err_inc_c = err_q + EW'(mism_c);
    assign begin_c   = start && (state_q != HOLD_ST);

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        vec_d        = vec_q;
        running_d    = running_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;

        if (abort) begin
            // Result registers survive an abort so software can still inspect them
            state_d   = IDLE;
            running_d = 1'b0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            vec_d     = '0;
        end else if (begin_c) begin
            state_d      = HOLD_ST;
            mask_d       = mask;
            idx_d        = '0;
            hold_d       = HW'(1);
            vec_d        = map_idx('0);
            running_d    = 1'b1;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            err_d        = '0;
            fail_valid_d = 1'b0;
            first_fail_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    vec_d = '0;
                end
                HOLD_ST: begin
                    if (hold_q == HW'(HOLD)) begin
                        err_d = err_inc_c;
                        if (mism_c && !fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            first_fail_d = vec_q;
                        end
                        if (idx_q == N_IN'(NV - 1)) begin
                            state_d   = DONE_ST;
                            running_d = 1'b0;
                            done_d    = 1'b1;
                            pass_d    = (err_inc_c == '0);
                        end else begin
                            idx_d  = idx_q + N_IN'(1);
                            vec_d  = map_idx(idx_q + N_IN'(1));
                            hold_d = HW'(1);
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                DONE_ST: begin
                    state_d = DONE_ST;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            hold_q       <= '0;
            vec_q        <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            vec_q        <= vec_d;
            running_q    <= running_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign vec        = vec_q;
    assign running    = running_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;

endmodule
